cpu_axi_arbiter: RTL



---
 rtl/cpu_axi_arbiter_if.sv | 63 ++++++
 rtl/cpu_axi_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/cpu_axi_arbiter_if.sv
// Core-side request/ack ports plus the AXI master channels of the fetch/data arbiter.
// master = arbiter view, slave = memory system / core environment view.
interface cpu_axi_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_data_ok;

   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_data_ok;

   logic        fetch_stall;
   logic        memory_stall;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;

   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [3:0]  bid;
   logic        bvalid;
   logic        bready;

   modport master (
      input  inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata,
      input  arready, rid, rdata, rlast, rvalid, awready, wready, bid, bvalid,
      output inst_rdata, inst_data_ok, data_rdata, data_data_ok, fetch_stall, memory_stall,
      output arid, araddr, arsize, arvalid, rready,
      output awid, awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready
   );

   modport slave (
      output inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata,
      output arready, rid, rdata, rlast, rvalid, awready, wready, bid, bvalid,
      input  inst_rdata, inst_data_ok, data_rdata, data_data_ok, fetch_stall, memory_stall,
      input  arid, araddr, arsize, arvalid, rready,
      input  awid, awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready
   );
endinterface

// File: rtl/cpu_axi_arbiter.sv
// Shares one AXI master between fetch and data ports, one transaction in flight; read data_ok
// two cycles after acceptance with a zero-wait slave, the losing requester stalls until served.
module cpu_axi_arbiter #(
   parameter logic [3:0] INST_ID       = 4'd0,
   parameter logic [3:0] DATA_ID       = 4'd1,
   parameter bit         DATA_PRIORITY = 1'b1
) (
   input  logic              aclk,
   input  logic              aresetn,
   cpu_axi_arbiter_if.master bus
);
   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_e;

   state_e      state_q, state_d;
   logic        owner_data_q, owner_data_d;
   logic [3:0]  id_q, id_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;

   logic        pick_data;
   logic        rd_done;
   logic        wr_done;
   logic        aw_hit;
   logic        w_hit;
   logic        wvalid_o;
   logic        inst_ok;
   logic        data_ok;
   logic [3:0]  strb_new;
   logic        unused_ids;

   always_comb begin
      case (bus.data_size)
         2'd0:    strb_new = 4'b0001 << bus.data_addr[1:0];
         2'd1:    strb_new = 4'b0011 << {bus.data_addr[1], 1'b0};
         default: strb_new = 4'b1111;
      endcase
   end

   assign pick_data = bus.data_req & (DATA_PRIORITY | ~bus.inst_req);
   assign rd_done   = (state_q == RD_DATA) & bus.rvalid & bus.rlast;
   assign wr_done   = (state_q == WR_RESP) & bus.bvalid;
   // aw and w complete independently; remember whichever finished first
   assign aw_hit    = aw_done_q | bus.awready;
   assign w_hit     = w_done_q | bus.wready;

   always_comb begin
      state_d      = state_q;
      owner_data_d = owner_data_q;
      id_d         = id_q;
      addr_d       = addr_q;
      size_d       = size_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      case (state_q)
         IDLE: begin
            if (bus.inst_req | bus.data_req) begin
               owner_data_d = pick_data;
               aw_done_d    = 1'b0;
               w_done_d     = 1'b0;
               if (pick_data) begin
                  id_d    = DATA_ID;
                  addr_d  = bus.data_addr;
                  size_d  = {1'b0, bus.data_size};
                  wdata_d = bus.data_wdata;
                  wstrb_d = strb_new;
                  state_d = bus.data_wr ? WR_ADDR : RD_ADDR;
               end else begin
                  id_d    = INST_ID;
                  addr_d  = bus.inst_addr;
                  size_d  = 3'd2;
                  wdata_d = '0;
                  wstrb_d = '0;
                  state_d = RD_ADDR;
               end
            end
         end
         RD_ADDR: if (bus.arready) state_d = RD_DATA;
         RD_DATA: if (bus.rvalid & bus.rlast) state_d = IDLE;
         WR_ADDR: begin
            if (aw_hit & w_hit) begin
               state_d   = WR_RESP;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end else begin
               aw_done_d = aw_hit;
               w_done_d  = w_hit;
            end
         end
         WR_RESP: if (bus.bvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         owner_data_q <= 1'b0;
         id_q         <= '0;
         addr_q       <= '0;
         size_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_data_q <= owner_data_d;
         id_q         <= id_d;
         addr_q       <= addr_d;
         size_q       <= size_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
      end
   end

   assign wvalid_o = (state_q == WR_ADDR) & ~w_done_q;
   assign inst_ok  = rd_done & ~owner_data_q;
   assign data_ok  = (rd_done | wr_done) & owner_data_q;

   assign bus.arid    = id_q;
   assign bus.araddr  = addr_q;
   assign bus.arsize  = size_q;
   assign bus.arvalid = (state_q == RD_ADDR);
   assign bus.rready  = (state_q == RD_DATA);
   assign bus.awid    = id_q;
   assign bus.awaddr  = addr_q;
   assign bus.awsize  = size_q;
   assign bus.awvalid = (state_q == WR_ADDR) & ~aw_done_q;
   assign bus.wdata   = wdata_q;
   assign bus.wstrb   = wstrb_q;
   assign bus.wlast   = wvalid_o;
   assign bus.wvalid  = wvalid_o;
   assign bus.bready  = (state_q == WR_RESP);

   assign bus.inst_data_ok = inst_ok;
   assign bus.data_data_ok = data_ok;
   assign bus.inst_rdata   = inst_ok ? bus.rdata : '0;
   assign bus.data_rdata   = data_ok ? bus.rdata : '0;
   // stalls are forced low while reset is held, even if the core keeps requesting
   assign bus.fetch_stall  = aresetn & bus.inst_req & ~inst_ok;
   assign bus.memory_stall = aresetn & bus.data_req & ~data_ok;

   assign unused_ids = ^{bus.rid, bus.bid};
endmodule
